// File: rtl/lpif_arb_pkg.sv
// Shared definitions for the LPIF upstream protid arbiter.
// Contents: arbitration FSM state type, LPIF channel field widths,
// arb_debug_status field offsets and the round-robin pointer helper.
package lpif_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int LPIF_DATA_W   = 128;
    localparam int LPIF_CRC_W    = 8;
    localparam int LPIF_PROTID_W = 2;

    // arb_debug_status layout
    localparam int DBG_OVERRUN_BIT = 31;
    localparam int DBG_GRANT_LSB   = 24;
    localparam int DBG_PKTCNT_LSB  = 0;

    // Index following idx, wrapping at n requesters.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/lpif_rr_pick.sv
// Combinational round-robin priority picker.
// Ports:
//   req       in  N  request vector
//   ptr       in  2  highest-priority index this cycle
//   grant_oh  out N  one-hot winner (0 when nothing requests)
//   grant_idx out 2  binary winner index
//   any       out 1  at least one request present
module lpif_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant_oh,
    output logic [1:0]   grant_idx,
    output logic         any
);

    logic [3:0] req_ext;
    logic [2:0] cand;

    assign req_ext = 4'(req);

    // Walk offsets from farthest to nearest so the requester closest to
    // ptr (in wrap order) is the last one written and therefore wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(N)) begin
                cand = cand - 3'(N);
            end
            if (req_ext[cand[1:0]]) begin
                grant_idx = cand[1:0];
                any       = 1'b1;
            end
        end
        grant_oh = '0;
        if (any) begin
            grant_oh = N'(4'b0001 << grant_idx);
        end
    end

endmodule

// File: rtl/lpif_ustrm_protid_arb.sv
// Packet-atomic round-robin arbiter sharing the 128-bit LPIF upstream
// channel between up to four protocol stacks, each tagged with a protid.
// Ports:
//   clk_wr, rst_wr_n           clock, asynchronous active-low reset
//   link_active, link_state    link usable flag and LPIF state
//   req_valid/data/last/crc/crc_vld   per-requester beat inputs
//   req_ready                  per-requester accept (valid & ready)
//   ustrm_*                    registered LPIF upstream outputs
//   arb_debug_status           {overrun, 3'b0, grant one-hot, 8'b0, pkt_count}
module lpif_ustrm_protid_arb
    import lpif_arb_pkg::*;
#(
    parameter int          NUM_REQ       = 4,
    parameter logic [7:0]  PROTID_MAP    = 8'hE4,
    parameter logic [15:0] MAX_PKT_BEATS = 16'd64
) (
    input  logic                         clk_wr,
    input  logic                         rst_wr_n,
    input  logic                         link_active,
    input  logic [3:0]                   link_state,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [LPIF_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [LPIF_CRC_W*NUM_REQ-1:0] req_crc,
    input  logic [NUM_REQ-1:0]           req_crc_vld,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [3:0]                   ustrm_state,
    output logic [LPIF_PROTID_W-1:0]     ustrm_protid,
    output logic [LPIF_DATA_W-1:0]       ustrm_data,
    output logic                         ustrm_dvalid,
    output logic [LPIF_CRC_W-1:0]        ustrm_crc,
    output logic                         ustrm_crc_valid,
    output logic                         ustrm_valid,
    output logic [31:0]                  arb_debug_status
);

    // Requester inputs widened to four slots so a 2-bit index is always legal.
    logic [LPIF_DATA_W-1:0] data_arr [4];
    logic [LPIF_CRC_W-1:0]  crc_arr  [4];
    logic [3:0]             valid_ext, last_ext, crc_vld_ext;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            if (gi < NUM_REQ) begin : g_used
                assign data_arr[gi]    = req_data[gi*LPIF_DATA_W +: LPIF_DATA_W];
                assign crc_arr[gi]     = req_crc[gi*LPIF_CRC_W +: LPIF_CRC_W];
                assign valid_ext[gi]   = req_valid[gi];
                assign last_ext[gi]    = req_last[gi];
                assign crc_vld_ext[gi] = req_crc_vld[gi];
            end else begin : g_unused
                assign data_arr[gi]    = '0;
                assign crc_arr[gi]     = '0;
                assign valid_ext[gi]   = 1'b0;
                assign last_ext[gi]    = 1'b0;
                assign crc_vld_ext[gi] = 1'b0;
            end
        end
    endgenerate

    arb_state_t  state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic [3:0]  grant_oh_reg, grant_oh_next;
    logic [1:0]  rr_ptr_reg, rr_ptr_next;
    logic [15:0] beat_cnt_reg, beat_cnt_next;
    logic [15:0] pkt_count_reg, pkt_count_next;
    logic        overrun_reg, overrun_next;

    logic [NUM_REQ-1:0] pick_oh;
    logic [1:0]         pick_idx;
    logic               pick_any;

    logic [1:0]  sel_idx;
    logic [3:0]  ready_vec;
    logic [15:0] cnt_inc;
    logic        accept;

    lpif_rr_pick #(.N(NUM_REQ)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_oh_next  = grant_oh_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_cnt_next  = beat_cnt_reg;
        pkt_count_next = pkt_count_reg;
        overrun_next   = overrun_reg;
        sel_idx        = grant_reg;
        ready_vec      = '0;
        cnt_inc        = beat_cnt_reg + 16'd1;

        case (state_reg)
            ARB_IDLE: begin
                // Selection and first-beat accept happen in the same cycle.
                sel_idx = pick_idx;
                cnt_inc = 16'd1;
                if (link_active && pick_any) begin
                    ready_vec = 4'(pick_oh);
                end
            end
            ARB_BURST: begin
                if (link_active) begin
                    ready_vec = grant_oh_reg;
                end
            end
            default: ;
        endcase

        accept = |(ready_vec & valid_ext);

        if (accept) begin
            if (state_reg == ARB_IDLE) begin
                grant_next    = pick_idx;
                grant_oh_next = 4'(pick_oh);
            end
            if (last_ext[sel_idx]) begin
                state_next     = ARB_IDLE;
                rr_ptr_next    = rr_next(sel_idx, NUM_REQ);
                pkt_count_next = pkt_count_reg + 16'd1;
            end else if (cnt_inc >= MAX_PKT_BEATS) begin
                // Runaway packet: release the channel; the tail re-arbitrates.
                state_next   = ARB_IDLE;
                rr_ptr_next  = rr_next(sel_idx, NUM_REQ);
                overrun_next = 1'b1;
            end else begin
                state_next    = ARB_BURST;
                beat_cnt_next = cnt_inc;
            end
        end
    end

    // Ready is combinational from inputs, so hold it low while in reset.
    assign req_ready = ready_vec[NUM_REQ-1:0] & {NUM_REQ{rst_wr_n}};

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state_reg     <= ARB_IDLE;
            grant_reg     <= '0;
            grant_oh_reg  <= '0;
            rr_ptr_reg    <= '0;
            beat_cnt_reg  <= '0;
            pkt_count_reg <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_oh_reg  <= grant_oh_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            pkt_count_reg <= pkt_count_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            ustrm_state     <= '0;
            ustrm_valid     <= 1'b0;
            ustrm_protid    <= '0;
            ustrm_data      <= '0;
            ustrm_crc       <= '0;
            ustrm_dvalid    <= 1'b0;
            ustrm_crc_valid <= 1'b0;
        end else begin
            ustrm_state     <= link_state;
            ustrm_valid     <= link_active;
            ustrm_dvalid    <= accept;
            ustrm_crc_valid <= accept & crc_vld_ext[sel_idx];
            if (accept) begin
                ustrm_protid <= PROTID_MAP[{sel_idx, 1'b0} +: 2];
                ustrm_data   <= data_arr[sel_idx];
                ustrm_crc    <= crc_arr[sel_idx];
            end
        end
    end

    always_comb begin
        arb_debug_status = '0;
        arb_debug_status[DBG_OVERRUN_BIT]       = overrun_reg;
        arb_debug_status[DBG_GRANT_LSB +: 4]    = grant_oh_reg;
        arb_debug_status[DBG_PKTCNT_LSB +: 16]  = pkt_count_reg;
    end

endmodule

// File: tb/tb_lpif_ustrm_protid_arb.sv
// Scoreboard bench for lpif_ustrm_protid_arb: directed packets are loaded
// into per-requester queues, the expected upstream beats are queued in the
// hand-derived grant order, and a monitor pops/compares on ustrm_dvalid.
// A second instance with MAX_PKT_BEATS = 4 shares the stimulus for the
// overrun case.
module tb_lpif_ustrm_protid_arb;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [7:0]   crc;
        logic         crc_vld;
    } beat_t;

    typedef struct packed {
        logic [1:0]   protid;
        logic [127:0] data;
        logic         crc_valid;
        logic [7:0]   crc;
    } exp_t;

    logic         clk_wr = 1'b0;
    logic         rst_wr_n = 1'b0;
    logic         link_active = 1'b0;
    logic [3:0]   link_state = 4'h0;
    logic [3:0]   req_valid = '0;
    logic [511:0] req_data = '0;
    logic [3:0]   req_last = '0;
    logic [31:0]  req_crc = '0;
    logic [3:0]   req_crc_vld = '0;

    logic [3:0]   req_ready;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [127:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [7:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;
    logic [31:0]  arb_debug_status;

    logic [3:0]   req_ready4;
    logic [3:0]   ustrm_state4;
    logic [1:0]   ustrm_protid4;
    logic [127:0] ustrm_data4;
    logic         ustrm_dvalid4;
    logic [7:0]   ustrm_crc4;
    logic         ustrm_crc_valid4;
    logic         ustrm_valid4;
    logic [31:0]  arb_debug_status4;

    lpif_ustrm_protid_arb dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .link_active(link_active), .link_state(link_state),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_crc(req_crc), .req_crc_vld(req_crc_vld), .req_ready(req_ready),
        .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid),
        .ustrm_data(ustrm_data), .ustrm_dvalid(ustrm_dvalid),
        .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
        .ustrm_valid(ustrm_valid), .arb_debug_status(arb_debug_status)
    );

    lpif_ustrm_protid_arb #(.MAX_PKT_BEATS(16'd4)) dut4 (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .link_active(link_active), .link_state(link_state),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_crc(req_crc), .req_crc_vld(req_crc_vld), .req_ready(req_ready4),
        .ustrm_state(ustrm_state4), .ustrm_protid(ustrm_protid4),
        .ustrm_data(ustrm_data4), .ustrm_dvalid(ustrm_dvalid4),
        .ustrm_crc(ustrm_crc4), .ustrm_crc_valid(ustrm_crc_valid4),
        .ustrm_valid(ustrm_valid4), .arb_debug_status(arb_debug_status4)
    );

    always #5 clk_wr = ~clk_wr;

    beat_t rq [4][$];
    exp_t  exp_q[$];
    int    acc_cnt [4];
    int    total = 0;
    int    bad = 0;
    int    dv_run = 0;
    int    max_run = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end else begin
            $display("check %s ok (%0h)", name, act);
        end
    endtask

    task automatic load(input int r, input logic [127:0] d, input logic last, input logic [7:0] crc);
        beat_t b;
        b.data    = d;
        b.last    = last;
        b.crc     = crc;
        b.crc_vld = last;
        rq[r].push_back(b);
    endtask

    task automatic expect_beat(input int r, input logic [127:0] d, input logic last, input logic [7:0] crc);
        exp_t e;
        e.protid    = 2'(r);
        e.data      = d;
        e.crc_valid = last;
        e.crc       = crc;
        exp_q.push_back(e);
    endtask

    task automatic send(input int r, input logic [127:0] d, input logic last, input logic [7:0] crc);
        load(r, d, last, crc);
        expect_beat(r, d, last, crc);
    endtask

    task automatic wait_acc(input int r, input int n);
        int c;
        c = 0;
        while (acc_cnt[r] < n && c < 300) begin
            @(posedge clk_wr);
            c++;
        end
        total++;
        if (acc_cnt[r] < n) begin
            bad++;
            $display("FAIL wait_acc_r%0d: got %0d accepted want %0d", r, acc_cnt[r], n);
        end
        @(negedge clk_wr);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(negedge clk_wr);
            c++;
        end
        repeat (2) @(negedge clk_wr);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d beats outstanding want 0", exp_q.size());
        end
    endtask

    task automatic flush_reqs();
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            acc_cnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_wr);
        rst_wr_n = 1'b0;
        flush_reqs();
        repeat (2) @(negedge clk_wr);
        rst_wr_n = 1'b1;
    endtask

    // Requester driver: present queue heads on the falling edge, decide
    // acceptance just before the rising edge.
    initial begin
        forever begin
            @(negedge clk_wr);
            for (int i = 0; i < 4; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]           = 1'b1;
                    req_data[i*128 +: 128] = rq[i][0].data;
                    req_last[i]            = rq[i][0].last;
                    req_crc[i*8 +: 8]      = rq[i][0].crc;
                    req_crc_vld[i]         = rq[i][0].crc_vld;
                end else begin
                    req_valid[i]   = 1'b0;
                    req_last[i]    = 1'b0;
                    req_crc_vld[i] = 1'b0;
                end
            end
            #4;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    acc_cnt[i]++;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_wr);
            if (ustrm_dvalid) begin
                dv_run++;
                if (dv_run > max_run) max_run = dv_run;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected: got protid=%0d data=%0h want no beat",
                             ustrm_protid, ustrm_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ustrm_protid !== e.protid || ustrm_data !== e.data ||
                        ustrm_crc_valid !== e.crc_valid ||
                        (e.crc_valid && ustrm_crc !== e.crc)) begin
                        bad++;
                        $display("FAIL beat: got protid=%0d data=%0h crcv=%0b crc=%0h want protid=%0d data=%0h crcv=%0b crc=%0h",
                                 ustrm_protid, ustrm_data, ustrm_crc_valid, ustrm_crc,
                                 e.protid, e.data, e.crc_valid, e.crc);
                    end else begin
                        $display("beat protid=%0d data=%0h crcv=%0b crc=%0h ok",
                                 ustrm_protid, ustrm_data, ustrm_crc_valid, ustrm_crc);
                    end
                end
            end else begin
                dv_run = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        link_state  = 4'h3;
        link_active = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_wr);
        check("rst_ctrl", {ustrm_valid, ustrm_dvalid, ustrm_crc_valid, ustrm_state, ustrm_protid, ustrm_crc}, '0);
        check("rst_data", ustrm_data, '0);
        check("rst_ready", req_ready, '0);
        check("rst_dbg", arb_debug_status, '0);
        rst_wr_n = 1'b1;
        @(negedge clk_wr);
        check("ustrm_valid_follow", ustrm_valid, 1'b1);
        check("ustrm_state_follow", ustrm_state, 4'h3);

        // 3-beat packet on requester 0
        max_run = 0;
        send(0, 128'hA0, 1'b0, 8'h00);
        send(0, 128'hA1, 1'b0, 8'h00);
        send(0, 128'hA2, 1'b1, 8'h5C);
        wait_drain();
        check("t1_run", max_run, 3);
        check("t1_pktcnt", arb_debug_status[15:0], 16'd1);
        check("t1_grant", arb_debug_status[27:24], 4'b0001);
        check("t1_overrun", arb_debug_status[31], 1'b0);

        // All four requesters with 1-beat packets: order 0,1,2,3,0,1,2,3
        do_reset();
        max_run = 0;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                send(i, 128'hB0 + 128'(rnd * 16 + i), 1'b1, 8'(8'h10 + i));
            end
        end
        wait_drain();
        check("t2_run", max_run, 8);
        check("t2_pktcnt", arb_debug_status[15:0], 16'd8);

        // Requester 2 must wait for requester 1's packet to finish
        for (int c = 0; c < 4; c++) send(1, 128'hC0 + 128'(c), c == 3, 8'h3C);
        wait_acc(1, 2);
        send(2, 128'hC8, 1'b1, 8'h2C);
        #4 check("t3_r2_blocked_a", req_ready[2], 1'b0);
        @(negedge clk_wr);
        #4 check("t3_r2_blocked_b", req_ready[2], 1'b0);
        wait_drain();
        check("t3_pktcnt", arb_debug_status[15:0], 16'd10);

        // 6-beat packet on requester 3: MAX 4 instance splits it
        for (int c = 0; c < 6; c++) send(3, 128'hE0 + 128'(c), c == 5, 8'hE5);
        wait_drain();
        check("t5_overrun4", arb_debug_status4[31], 1'b1);
        check("t5_overrun64", arb_debug_status[31], 1'b0);
        check("t5_pktcnt4", arb_debug_status4[15:0], 16'd11);
        check("t5_grant4", arb_debug_status4[27:24], 4'b1000);

        // link_active drop for 5 cycles during beat 3 of 6
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        for (int c = 0; c < 6; c++) send(0, 128'hF0 + 128'(c), c == 5, 8'hF5);
        wait_acc(0, 2);
        link_active = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #4 check("t4_ready_down", req_ready, 4'b0000);
            @(negedge clk_wr);
            check("t4_out_down", {ustrm_dvalid, ustrm_valid}, 2'b00);
        end
        link_active = 1'b1;
        wait_drain();
        check("t4_pktcnt", arb_debug_status[15:0], 16'd12);

        // Asynchronous reset mid-burst on requester 2
        for (int i = 0; i < 4; i++) acc_cnt[i] = 0;
        for (int c = 0; c < 4; c++) load(2, 128'hD0 + 128'(c), c == 3, 8'hDD);
        expect_beat(2, 128'hD0, 1'b0, 8'h00);
        expect_beat(2, 128'hD1, 1'b0, 8'h00);
        wait_acc(2, 2);
        #2 rst_wr_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {ustrm_valid, ustrm_dvalid, ustrm_crc_valid, ustrm_state, ustrm_protid, ustrm_crc}, '0);
        check("t6_rst_data", ustrm_data, '0);
        check("t6_rst_ready", req_ready, '0);
        check("t6_rst_dbg", arb_debug_status, '0);
        flush_reqs();
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        send(1, 128'h91, 1'b1, 8'h91);
        send(3, 128'h93, 1'b1, 8'h93);
        wait_drain();
        check("t6_pktcnt", arb_debug_status[15:0], 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpif_ustrm_protid_arb.md
Name: lpif_ustrm_protid_arb

Overview:
- Round-robin, packet-atomic arbiter that shares the single 128-bit LPIF upstream channel (ustrm_*) between up to four protocol-stack requesters, each bound to one protid.
- Sits between the protocol stacks and the x8 asym2 slave top; its registered outputs drive ustrm_* directly.
- The LPIF channel has no ready, so the block is the only flow-control point. Requesters are back-pressured through per-requester ready, gated by link_active.

Parameters:
- NUM_REQ, 4, number of requesters (1..4); requester i is sent with protid = PROTID_MAP[2*i +: 2].
- PROTID_MAP, 8'hE4, packed 2-bit protid per requester (default: i -> i).
- MAX_PKT_BEATS, 16'd64, beat limit per packet; exceeding it forces release and sets the overrun flag.

Ports:
- clk_wr  in  1  clock.
- rst_wr_n  in  1  asynchronous active-low reset.
- link_active  in  1  link usable (tx_online_delay AND LPIF state = Active).
- link_state  in  4  LPIF state forwarded onto ustrm_state.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  128*NUM_REQ  per-requester beat data.
- req_last  in  NUM_REQ  last beat of packet.
- req_crc  in  8*NUM_REQ  CRC, meaningful with req_last.
- req_crc_vld  in  NUM_REQ  CRC present on this beat.
- req_ready  out  NUM_REQ  beat accepted when valid&ready.
- ustrm_state  out  4  registered link_state.
- ustrm_protid  out  2  protid of current beat.
- ustrm_data  out  128  beat data.
- ustrm_dvalid  out  1  data valid.
- ustrm_crc  out  8  CRC.
- ustrm_crc_valid  out  1  CRC valid.
- ustrm_valid  out  1  registered link_active.
- arb_debug_status  out  32  {overrun_sticky, 3'b0, cur_grant[3:0], 8'b0, pkt_count[15:0]}.

Behaviour:
- Reset values: all ustrm_* outputs 0; req_ready 0; arb_debug_status 0; state IDLE; rr_ptr 0.
- FSM states: IDLE, BURST.
- IDLE:
  - If link_active and any req_valid, select the first requesting index starting at rr_ptr, wrapping modulo NUM_REQ. Store it as grant.
  - The selecting cycle is combinational: req_ready[grant] = 1 in the same cycle, so the first beat is accepted with zero bubble.
  - If that beat has req_last, stay in IDLE; otherwise go to BURST.
  - rr_ptr advances to grant+1 (mod NUM_REQ) on acceptance of the last beat.
- BURST:
  - Grant is locked. req_ready[grant] = link_active; all other readies are 0.
  - Accepted beat with req_last -> IDLE, rr_ptr = grant+1, pkt_count += 1 (wraps at 16'hFFFF -> 0).
  - Beat counter reaches MAX_PKT_BEATS without last -> IDLE, overrun_sticky = 1, rr_ptr = grant+1. Remaining beats of that packet are arbitrated as a new packet.
- Output pipeline: one register stage; latency from accepted beat to ustrm_dvalid is 1 cycle.
  - On accept: ustrm_data/protid/crc load from the granted requester; ustrm_dvalid = 1; ustrm_crc_valid = req_crc_vld[grant].
  - Otherwise ustrm_dvalid = 0 and ustrm_crc_valid = 0. ustrm_data and ustrm_protid hold their previous values.
- link_active drop mid-packet:
  - All req_ready go to 0; the FSM stays in BURST holding the grant; no beats are lost.
  - The packet resumes when link_active returns.
- ustrm_valid and ustrm_state are registered copies of link_active and link_state, 1-cycle latency, independent of arbitration.
- A requester that deasserts valid mid-packet is not an error: the grant is held and other requesters wait.
- Simultaneous last-beat accept and new requests: the next grant is evaluated in the following cycle (IDLE), using the updated rr_ptr.
- NUM_REQ = 1: grant is always 0 and rr_ptr is constant.
- Reset mid-packet: everything returns to reset values immediately (asynchronous); the partial packet is discarded downstream by the protocol layer.
- overrun_sticky clears only on reset.

Decomposition:
- Shared package lpif_arb_pkg: FSM state enum (ARB_IDLE, ARB_BURST), LPIF_DATA_W = 128, LPIF_CRC_W = 8, LPIF_PROTID_W = 2, debug status field offsets.
- One natural sub-module: lpif_rr_pick. It is a combinational round-robin priority picker (req vector, rr_ptr -> one-hot grant, grant index, any).

Test Plan:
- Reset, link_active=1, req_valid=4'b0001, 3-beat packet (data 0xA0, 0xA1, 0xA2; last on beat 3 with crc 0x5C) -> ustrm_dvalid high for 3 consecutive cycles starting 1 cycle after accept; protid 0; crc_valid=1 with crc 0x5C on the third beat only; pkt_count = 1.
- All four requesters continuously valid with 1-beat packets -> grant order 0, 1, 2, 3, 0, ...; ustrm_protid sequence 0, 1, 2, 3; no idle cycle between beats.
- Requester 1 mid-packet (beat 2 of 4) while requester 2 requests -> requester 2 gets no ready until requester 1's last beat; requester 2's first beat appears on the next arbitration.
- link_active drops for 5 cycles during beat 3 of a 6-beat packet -> req_ready = 0 and ustrm_dvalid = 0 for those cycles; ustrm_valid = 0 one cycle later; the remaining beats follow in order after recovery with no loss.
- MAX_PKT_BEATS=4, 6-beat packet on requester 3 -> forced release after 4 beats; arb_debug_status[31] = 1; remaining 2 beats are sent after re-arbitration.
- Assert rst_wr_n low during a burst -> all outputs 0 asynchronously; after release, rr_ptr = 0 and first grant goes to the lowest valid requester.
